mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL provide parameter MODULUS, default 16, count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous active-low reset.
REQ-005 SHALL provide port en  input  1  count enable, sampled each rising edge.
REQ-006 SHALL provide port up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-007 SHALL provide port load  input  1  synchronous preset request.
REQ-008 SHALL provide port load_val  input  WIDTH  preset value.
REQ-009 SHALL provide port counter  output  WIDTH  registered count value.
REQ-010 SHALL provide port carry_out  output  1  registered one-cycle wrap pulse, for cascading into the next stage's en.
REQ-011 SHALL provide port at_term  output  1  combinational terminal-count flag: counter==MODULUS-1 when up_dn=1, counter==0 when up_dn=0.

Function
REQ-012 Edge priority SHALL be: rst low > load > en > hold.
REQ-013 With en=1 and up_dn=1, counter SHALL increment by 1, wrapping MODULUS-1 -> 0.
REQ-014 With en=1 and up_dn=0, counter SHALL decrement by 1, wrapping 0 -> MODULUS-1.
REQ-015 With en=0 and no load, counter SHALL hold its value; carry_out SHALL be 0.
REQ-016 carry_out SHALL be 1 for exactly the one cycle after an edge at which a wrap occurred, coincident with counter showing the wrapped value; otherwise 0.
REQ-017 Back-to-back wraps (MODULUS=2, en held high) SHALL produce carry_out high on every wrap cycle.
REQ-018 Direction change SHALL take effect at the next enabled edge; no wrap or carry SHALL result from the change itself.
REQ-019 Counter value SHALL never leave 0..MODULUS-1 under any input sequence.
REQ-020 Arithmetic SHALL be WIDTH bits, with wrap decided by comparison against MODULUS-1 or 0, not by natural overflow, so non-power-of-two MODULUS works.

Reset
REQ-021 When rst=0 at a rising edge, counter SHALL become 0 and carry_out SHALL become 0, regardless of en, load or up_dn.
REQ-022 Reset asserted mid-count SHALL take effect at that edge; no carry SHALL be emitted for the interrupted count.
REQ-023 At the first edge after rst returns high, normal priority SHALL apply, so en=1, up_dn=1 gives counter=1.
REQ-024 Outputs SHALL be undefined only before the first reset edge.

Configuration
REQ-025 Macro MOD_COUNTER_PRESET_EN SHALL compile in the preset feature.
REQ-026 With MOD_COUNTER_PRESET_EN defined, load=1 SHALL set counter to load_val at the edge, or to MODULUS-1 if load_val>=MODULUS; carry_out SHALL be 0 that cycle, even if en=1.
REQ-027 Without MOD_COUNTER_PRESET_EN, load and load_val SHALL remain as ports but be ignored, and no preset logic SHALL be synthesised.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-028 Reset, then 12 single-cycle en pulses with up_dn=1 -> counter 1..9,0,1,2; carry_out high only in the cycle counter first reads 0.
REQ-029 Reset, then up_dn=0, en=1 for 3 edges -> counter 9,8,7; carry_out high only with counter=9.
REQ-030 Count to 5, drive rst=0 for 2 edges with en=1 -> counter=0 and carry_out=0 on both, then 1 on the first edge after release.
REQ-031 With MOD_COUNTER_PRESET_EN: load=1, load_val=7, en=1 -> counter=7, carry_out=0; load_val=12 -> counter=9. Without the macro, the same stimulus -> normal increment.
REQ-032 MODULUS=16, en held high for 40 edges -> counter wraps 15->0 twice, with exactly 2 carry_out pulses; at_term high whenever counter=15.
REQ-033 MODULUS=2, en held high -> counter alternates 0,1, with carry_out high on every counter=0 cycle.

Source files
------------

// File: rtl/mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mod_counter                                                |
// | Description : Up/down modulo-MODULUS counter with a registered wrap      |
// |               pulse for cascading and a combinational terminal-count     |
// |               flag. Optional synchronous preset compiled in by the       |
// |               MOD_COUNTER_PRESET_EN macro.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16  // legal range 2 .. 2**WIDTH
) (
  input  logic             clk,
  input  logic             rst,       // synchronous, active low
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             carry_out,
  output logic             at_term
);

  // Wrap points are decided by compare, never by natural overflow, so any
  // MODULUS in range works, not only powers of two.
  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;
  logic             carry_q;
  logic             carry_d;

`ifdef MOD_COUNTER_PRESET_EN
  // Out-of-range preset values saturate to the terminal value so the count
  // can never leave 0..MODULUS-1.
  localparam logic [WIDTH:0] C_MOD_EXT = (WIDTH + 1)'(MODULUS);
  logic [WIDTH-1:0] w_preset_val;
  assign w_preset_val = ({1'b0, load_val} >= C_MOD_EXT) ? C_MAX : load_val;
`else
  // Preset ports stay on the boundary but drive nothing.
  logic w_unused_load;
  assign w_unused_load = ^{load, load_val};
`endif

  // Next-state: preset beats counting; a wrap raises carry for one cycle.
  always_comb begin
    counter_d = counter_q;
    carry_d   = 1'b0;
`ifdef MOD_COUNTER_PRESET_EN
    if (load) begin
      counter_d = w_preset_val;
    end else if (en) begin
`else
    if (en) begin
`endif
      if (up_dn) begin
        if (counter_q == C_MAX) begin
          counter_d = C_ZERO;
          carry_d   = 1'b1;
        end else begin
          counter_d = counter_q + C_ONE;
        end
      end else begin
        if (counter_q == C_ZERO) begin
          counter_d = C_MAX;
          carry_d   = 1'b1;
        end else begin
          counter_d = counter_q - C_ONE;
        end
      end
    end
  end

  // State register; reset wins over every other request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      counter_q <= C_ZERO;
      carry_q   <= 1'b0;
    end else begin
      counter_q <= counter_d;
      carry_q   <= carry_d;
    end
  end

  assign counter   = counter_q;
  assign carry_out = carry_q;
  assign at_term   = up_dn ? (counter_q == C_MAX) : (counter_q == C_ZERO);

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mod_counter                                             |
// | Description : Three counter instances (MODULUS 10, 16, 2) driven by      |
// |               directed and random stimulus against an arithmetic model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mod_counter;

`ifdef MOD_COUNTER_PRESET_EN
  localparam bit PRESET = 1'b1;
`else
  localparam bit PRESET = 1'b0;
`endif
  localparam int MODS [3] = '{10, 16, 2};

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] en;
  logic [2:0] up_dn;
  logic [2:0] load;
  logic [3:0] lv   [3];
  logic [3:0] cnt  [3];
  logic       car  [3];
  logic       term [3];

  int checks = 0;
  int errors = 0;

  int mc   [3];
  bit mcar [3];
  bit mval [3];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .up_dn(up_dn[0]), .load(load[0]),
    .load_val(lv[0]), .counter(cnt[0]), .carry_out(car[0]), .at_term(term[0]));
  mod_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .up_dn(up_dn[1]), .load(load[1]),
    .load_val(lv[1]), .counter(cnt[1]), .carry_out(car[1]), .at_term(term[1]));
  mod_counter #(.WIDTH(4), .MODULUS(2)) u_m2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .up_dn(up_dn[2]), .load(load[2]),
    .load_val(lv[2]), .counter(cnt[2]), .carry_out(car[2]), .at_term(term[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic; a wrap is a step that moves the
  // value against the counting direction.
  function automatic int nxt_cnt(int c, int m, bit r, bit ld, int v, bit e, bit u);
    if (!r) return 0;
    if (PRESET && ld) return (v >= m) ? m - 1 : v;
    if (e) return u ? (c + 1) % m : (c + m - 1) % m;
    return c;
  endfunction

  function automatic bit nxt_car(int c, int m, bit r, bit ld, int v, bit e, bit u);
    int n;
    if (!r || (PRESET && ld) || !e) return 1'b0;
    n = nxt_cnt(c, m, r, ld, v, e, u);
    return u ? (n < c) : (n > c);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mc[i]   <= nxt_cnt(mc[i], MODS[i], rst[i], load[i], int'(lv[i]), en[i], up_dn[i]);
      mcar[i] <= nxt_car(mc[i], MODS[i], rst[i], load[i], int'(lv[i]), en[i], up_dn[i]);
      if (!rst[i]) mval[i] <= 1'b1;
    end
  end

  // Compare every instance against the model on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mval[i]) begin
        chk($sformatf("dut%0d counter", i), int'(cnt[i]), mc[i]);
        chk($sformatf("dut%0d carry_out", i), int'(car[i]), int'(mcar[i]));
        chk($sformatf("dut%0d at_term", i), int'(term[i]),
            int'(up_dn[i] ? (mc[i] == MODS[i] - 1) : (mc[i] == 0)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit r, input bit e, input bit u, input bit ld, input int v);
    rst[0] = r; en[0] = e; up_dn[0] = u; load[0] = ld; lv[0] = 4'(v);
    tick();
  endtask

  initial begin
    int pulses;
    rst = 3'b000; en = 3'b000; up_dn = 3'b111; load = 3'b000;
    for (int i = 0; i < 3; i++) lv[i] = 4'd0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset counter dut%0d", i), int'(cnt[i]), 0);
      chk($sformatf("reset carry dut%0d", i), int'(car[i]), 0);
    end
    rst = 3'b111;

    // Twelve single-cycle enable pulses counting up.
    for (int k = 1; k <= 12; k++) begin
      drive0(1, 1, 1, 0, 0);
      chk($sformatf("up pulse %0d counter", k), int'(cnt[0]), k % 10);
      chk($sformatf("up pulse %0d carry", k), int'(car[0]), int'(k == 10));
      drive0(1, 0, 1, 0, 0);
      chk($sformatf("up hold %0d counter", k), int'(cnt[0]), k % 10);
      chk($sformatf("up hold %0d carry", k), int'(car[0]), 0);
    end

    // Count down from reset.
    drive0(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive0(1, 1, 0, 0, 0);
      chk($sformatf("down %0d counter", k), int'(cnt[0]), 9 - k);
      chk($sformatf("down %0d carry", k), int'(car[0]), int'(k == 0));
    end

    // Reset mid-count, held for two edges with en high.
    drive0(0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) drive0(1, 1, 1, 0, 0);
    chk("count to 5", int'(cnt[0]), 5);
    for (int k = 0; k < 2; k++) begin
      drive0(0, 1, 1, 0, 0);
      chk("midreset counter", int'(cnt[0]), 0);
      chk("midreset carry", int'(car[0]), 0);
    end
    drive0(1, 1, 1, 0, 0);
    chk("release counter", int'(cnt[0]), 1);

    // Preset with en high; in-range then out-of-range value.
    drive0(1, 1, 1, 1, 7);
    chk("preset 7 counter", int'(cnt[0]), PRESET ? 7 : 2);
    chk("preset 7 carry", int'(car[0]), 0);
    drive0(1, 1, 1, 1, 12);
    chk("preset 12 counter", int'(cnt[0]), PRESET ? 9 : 3);
    chk("preset 12 carry", int'(car[0]), 0);
    drive0(1, 0, 1, 0, 0);

    // Modulus 16, forty enabled edges.
    en[1] = 1'b1; up_dn[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (car[1]) pulses++;
    end
    chk("m16 carry pulses", pulses, 2);
    chk("m16 final counter", int'(cnt[1]), 8);
    en[1] = 1'b0;

    // Modulus 2, back-to-back wraps.
    en[2] = 1'b1; up_dn[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("m2 edge %0d counter", k), int'(cnt[2]), k % 2);
      chk($sformatf("m2 edge %0d carry", k), int'(car[2]), int'(k % 2 == 0));
    end

    // Random traffic on all instances.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 3; i++) begin
        rst[i]   = ($urandom_range(0, 19) != 0);
        en[i]    = 1'($urandom_range(0, 3) != 0);
        up_dn[i] = 1'($urandom_range(0, 1));
        load[i]  = ($urandom_range(0, 7) == 0);
        lv[i]    = 4'($urandom_range(0, 15));
      end
      tick();
    end
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
